hub75_stream_writer: RTL and testbench

Pixel-stream front end for the HUB75 frame buffer write port. Accepts a raster-ordered pixel stream (valid/ready, start-of-frame flag), writes each line into the framebuffer line buffer, and commits it with the row store/swap handshake. After the last line it requests a frame swap. It sits between any pixel source (video decoder, SPI/USB loader, pattern generator) and the `fbw_*` / `frame_*` ports of the HUB75 core.

---
 rtl/hub75_stream_writer.sv | 205 ++++++++++++++++++++
 tb/tb_hub75_stream_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_stream_writer.sv
// hub75_stream_writer
//   Pixel-stream front end for the HUB75 framebuffer write port. Takes a
//   raster-ordered valid/ready pixel stream with a start-of-frame flag,
//   writes each line into the framebuffer line buffer, commits it with the
//   row store/swap handshake and requests a frame swap after the last line.
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   in_data/in_sof/in_valid   pixel stream input
//   in_ready                  stream back-pressure
//   fbw_bank_addr/row_addr    line address for the store (registered)
//   fbw_row_store/row_swap    one-cycle store + line-buffer swap
//   fbw_row_rdy               framebuffer idle
//   fbw_data/col_addr/wren    registered line-buffer write port
//   frame_swap/frame_rdy      frame swap request / no swap pending
//   err_sync                  one-cycle pulse on a misplaced start-of-frame
module hub75_stream_writer #(
    parameter int N_BANKS     = 2,
    parameter int N_ROWS      = 32,
    parameter int N_COLS      = 64,
    parameter int BITDEPTH    = 24,
    parameter int LOG_N_BANKS = $clog2(N_BANKS),
    parameter int LOG_N_ROWS  = $clog2(N_ROWS),
    parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BITDEPTH-1:0]    in_data,
    input  logic                   in_sof,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LOG_N_BANKS-1:0] fbw_bank_addr,
    output logic [LOG_N_ROWS-1:0]  fbw_row_addr,
    output logic                   fbw_row_store,
    input  logic                   fbw_row_rdy,
    output logic                   fbw_row_swap,
    output logic [BITDEPTH-1:0]    fbw_data,
    output logic [LOG_N_COLS-1:0]  fbw_col_addr,
    output logic                   fbw_wren,
    output logic                   frame_swap,
    input  logic                   frame_rdy,
    output logic                   err_sync
);

    localparam int YW = LOG_N_BANKS + LOG_N_ROWS;
    localparam logic [LOG_N_COLS-1:0] LAST_X = LOG_N_COLS'(N_COLS - 1);
    localparam logic [YW-1:0]         LAST_Y = YW'(N_BANKS * N_ROWS - 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_FILL,
        S_LINE_END,
        S_WAIT_RDY,
        S_FRAME_END,
        S_FRAME_SWAP,
        S_FRAME_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [LOG_N_COLS-1:0]  x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [1:0]             guard_q, guard_d;
    logic                   wren_q, wren_d;
    logic [LOG_N_COLS-1:0]  col_q, col_d;
    logic [BITDEPTH-1:0]    data_q, data_d;
    logic [LOG_N_BANKS-1:0] bank_q, bank_d;
    logic [LOG_N_ROWS-1:0]  row_q, row_d;
    logic                   err_q, err_d;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        guard_d       = guard_q;
        wren_d        = 1'b0;
        col_d         = col_q;
        data_d        = data_q;
        bank_d        = bank_q;
        row_d         = row_q;
        err_d         = 1'b0;
        in_ready      = 1'b0;
        fbw_row_store = 1'b0;
        fbw_row_swap  = 1'b0;
        frame_swap    = 1'b0;

        case (state_q)
            S_SYNC: begin
                in_ready = 1'b1;
                // Beats without start-of-frame are silently dropped here.
                if (in_valid && in_sof) begin
                    wren_d  = 1'b1;
                    col_d   = '0;
                    data_d  = in_data;
                    x_d     = LOG_N_COLS'(1);
                    y_d     = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wren_d = 1'b1;
                    data_d = in_data;
                    if (in_sof && (x_q != '0 || y_q != '0)) begin
                        // Misplaced SOF: restart the frame with this beat.
                        err_d = 1'b1;
                        col_d = '0;
                        x_d   = LOG_N_COLS'(1);
                        y_d   = '0;
                    end else begin
                        col_d = x_q;
                        x_d   = x_q + LOG_N_COLS'(1);
                        if (x_q == LAST_X) begin
                            state_d = S_LINE_END;
                        end
                    end
                end
            end
            S_LINE_END: begin
                // Latch the line address so it holds across the store.
                bank_d  = y_q[YW-1:LOG_N_ROWS];
                row_d   = y_q[LOG_N_ROWS-1:0];
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (fbw_row_rdy) begin
                    fbw_row_store = 1'b1;
                    fbw_row_swap  = 1'b1;
                    if (y_q == LAST_Y) begin
                        y_d     = '0;
                        guard_d = '0;
                        state_d = S_FRAME_END;
                    end else begin
                        y_d     = y_q + YW'(1);
                        state_d = S_FILL;
                    end
                end
            end
            S_FRAME_END: begin
                // fbw_row_rdy may still reflect the pre-store idle state for
                // two cycles, so it is only trusted after the guard expires.
                if (guard_q != 2'd2) begin
                    guard_d = guard_q + 2'd1;
                end else if (fbw_row_rdy) begin
                    state_d = S_FRAME_SWAP;
                end
            end
            S_FRAME_SWAP: begin
                frame_swap = 1'b1;
                guard_d    = '0;
                state_d    = S_FRAME_WAIT;
            end
            S_FRAME_WAIT: begin
                if (guard_q == 2'd0) begin
                    guard_d = 2'd1;
                end else if (frame_rdy) begin
                    state_d = S_SYNC;
                end
            end
            default: state_d = S_SYNC;
        endcase

        // Reset suppresses every combinational strobe in the reset cycle.
        if (rst) begin
            in_ready      = 1'b0;
            fbw_row_store = 1'b0;
            fbw_row_swap  = 1'b0;
            frame_swap    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SYNC;
            x_q     <= '0;
            y_q     <= '0;
            guard_q <= '0;
            wren_q  <= 1'b0;
            col_q   <= '0;
            data_q  <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            guard_q <= guard_d;
            wren_q  <= wren_d;
            col_q   <= col_d;
            data_q  <= data_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    assign fbw_wren      = wren_q;
    assign fbw_col_addr  = col_q;
    assign fbw_data      = data_q;
    assign fbw_bank_addr = bank_q;
    assign fbw_row_addr  = row_q;
    assign err_sync      = err_q;

endmodule

// File: tb/tb_hub75_stream_writer.sv
// Directed bench for hub75_stream_writer (2 banks x 32 rows x 64 cols, 24 bpp).
// Inputs change at the falling edge; every signal is sampled 1 time unit
// later, which is what the following rising edge will see.
module tb_hub75_stream_writer;

    logic        clk;
    logic        rst;
    logic [23:0] in_data;
    logic        in_sof;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  fbw_bank_addr;
    logic [4:0]  fbw_row_addr;
    logic        fbw_row_store;
    logic        fbw_row_rdy;
    logic        fbw_row_swap;
    logic [23:0] fbw_data;
    logic [5:0]  fbw_col_addr;
    logic        fbw_wren;
    logic        frame_swap;
    logic        frame_rdy;
    logic        err_sync;

    hub75_stream_writer #(
        .N_BANKS (2),
        .N_ROWS  (32),
        .N_COLS  (64),
        .BITDEPTH(24)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fbw_bank_addr(fbw_bank_addr),
        .fbw_row_addr (fbw_row_addr),
        .fbw_row_store(fbw_row_store),
        .fbw_row_rdy  (fbw_row_rdy),
        .fbw_row_swap (fbw_row_swap),
        .fbw_data     (fbw_data),
        .fbw_col_addr (fbw_col_addr),
        .fbw_wren     (fbw_wren),
        .frame_swap   (frame_swap),
        .frame_rdy    (frame_rdy),
        .err_sync     (err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // source
    int src_on, p, sof_a, sof_b;
    // observation log
    int cyc, n_wr, n_st, n_fs, n_err, wr_bad, overlap, swapmis, fs_cyc, bad;
    int st_bank[64], st_row[64], st_cyc[64];
    int last_bank, last_row;
    int first_col, first_data, sof_col, sof_data;
    logic prev_acc, prev_sof, last_rdy, cur_store;
    logic [23:0] prev_data;
    logic [40:0] snap_outs;

    function automatic logic [23:0] pix(int k);
        return {8'hC3, 16'(k)};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        n_wr = 0; n_st = 0; n_fs = 0; n_err = 0;
        wr_bad = 0; overlap = 0; swapmis = 0; fs_cyc = 0;
    endtask

    // Sample the current cycle, log events, advance to the next falling edge.
    task automatic tick();
        logic acc;
        #1;
        acc       = in_valid && in_ready;
        last_rdy  = in_ready;
        cur_store = fbw_row_store;
        snap_outs = {fbw_wren, fbw_row_store, fbw_row_swap, frame_swap, err_sync,
                     fbw_col_addr, fbw_data, fbw_bank_addr, fbw_row_addr};
        if (fbw_wren) begin
            if (n_wr == 0) begin
                first_col  = int'(fbw_col_addr);
                first_data = int'(fbw_data);
            end
            if (prev_sof) begin
                sof_col  = int'(fbw_col_addr);
                sof_data = int'(fbw_data);
            end
            if (!prev_acc || fbw_data !== prev_data || int'(fbw_col_addr) != (n_wr % 64))
                wr_bad++;
            n_wr++;
        end
        if (fbw_row_store) begin
            if (n_st < 64) begin
                st_bank[n_st] = int'(fbw_bank_addr);
                st_row[n_st]  = int'(fbw_row_addr);
                st_cyc[n_st]  = cyc;
            end
            last_bank = int'(fbw_bank_addr);
            last_row  = int'(fbw_row_addr);
            n_st++;
            if (fbw_wren) overlap++;
        end
        if (fbw_row_store !== fbw_row_swap) swapmis++;
        if (frame_swap) begin
            fs_cyc = cyc;
            n_fs++;
        end
        if (err_sync) n_err++;
        prev_acc  = acc;
        prev_sof  = acc && in_sof;
        prev_data = in_data;
        if (acc) p++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        in_valid = (src_on != 0);
        in_sof   = (src_on != 0) && (p == sof_a || p == sof_b);
        in_data  = pix(p);
        tick();
    endtask

    task automatic check_frame_stores(string tag);
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (st_bank[k] != k / 32 || st_row[k] != k % 32) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        fbw_row_rdy = 1'b1; frame_rdy = 1'b1;
        src_on = 0; p = 0; sof_a = -1; sof_b = -1; cyc = 0;
        prev_acc = 1'b0; prev_sof = 1'b0; prev_data = '0;
        last_bank = 0; last_row = 0; first_col = 0; first_data = 0;
        sof_col = 0; sof_data = 0;
        clear_logs();
        @(negedge clk);

        // ---- reset state ----
        step();
        check("rst_rdy", last_rdy, 0);
        check("rst_outs", snap_outs, 0);
        step();
        check("rst_outs2", snap_outs, 0);
        rst = 1'b0;
        step();
        check("rel_rdy", last_rdy, 1);
        check("rel_outs", snap_outs, 0);

        // ---- full frame, no back-pressure ----
        clear_logs(); p = 0; sof_a = 0; sof_b = -1; src_on = 1;
        for (int i = 0; i < 6000 && n_fs == 0; i++) step();
        check("ff_fs_seen", n_fs, 1);
        repeat (10) step();
        check("ff_stores", n_st, 64);
        check("ff_writes", n_wr, 4096);
        check("ff_wr_bad", wr_bad, 0);
        check("ff_overlap", overlap, 0);
        check("ff_swap_eq_store", swapmis, 0);
        check("ff_fs_count", n_fs, 1);
        check("ff_err", n_err, 0);
        check_frame_stores("ff_store_addr");
        bad = 0;
        for (int k = 1; k < 64; k++)
            if (st_cyc[k] - st_cyc[k-1] != 66) bad++;
        check("ff_line_spacing", bad, 0);
        check("ff_fs_delay", fs_cyc - st_cyc[63], 4);

        // ---- row_rdy held low at line 5 end, frame_rdy held low ----
        clear_logs(); sof_a = p + 2; sof_b = -1; frame_rdy = 1'b0;
        for (int i = 0; i < 1000 && n_st < 5; i++) step();
        check("rr_five_stores", n_st, 5);
        fbw_row_rdy = 1'b0;
        for (int i = 0; i < 200 && n_wr < 384; i++) step();
        check("rr_line5_written", n_wr, 384);
        check("rr_line_end_rdy", last_rdy, 0);
        bad = 0;
        repeat (10) begin
            step();
            if (last_rdy || cur_store) bad++;
        end
        check("rr_hold_quiet", bad, 0);
        check("rr_no_store", n_st, 5);
        fbw_row_rdy = 1'b1;
        step();
        check("rr_store_now", n_st, 6);
        check("rr_store_bank", last_bank, 0);
        check("rr_store_row", last_row, 5);
        for (int i = 0; i < 6000 && n_fs == 0; i++) step();
        check("fr_fs_seen", n_fs, 1);
        check("fr_stores", n_st, 64);
        check("fr_wr_bad", wr_bad, 0);
        bad = 0;
        repeat (20) begin
            step();
            if (last_rdy) bad++;
        end
        check("fr_hold_rdy_low", bad, 0);
        frame_rdy = 1'b1;
        step();
        check("fr_return_cycle_rdy", last_rdy, 0);
        step();
        check("fr_after_rdy", last_rdy, 1);

        // ---- dropped beats from reset, then misplaced SOF ----
        rst = 1'b1; src_on = 0;
        step();
        rst = 1'b0;
        clear_logs(); p = 0; sof_a = 7; sof_b = 7 + 3 * 64 + 10; src_on = 1;
        repeat (8) step();
        check("drop_no_wren", n_wr, 0);
        step();
        check("drop_first_write", n_wr, 1);
        check("drop_first_col", first_col, 0);
        check("drop_first_data", first_data, int'(pix(7)));
        check("drop_no_err", n_err, 0);
        for (int i = 0; i < 400 && n_err == 0; i++) step();
        check("es_err_once", n_err, 1);
        check("es_stores_before", n_st, 3);
        check("es_restart_col", sof_col, 0);
        check("es_restart_data", sof_data, int'(pix(sof_b)));
        for (int i = 0; i < 200 && n_st < 4; i++) step();
        check("es_next_store", n_st, 4);
        check("es_next_bank", last_bank, 0);
        check("es_next_row", last_row, 0);
        check("es_no_fs", n_fs, 0);
        check("es_err_still_once", n_err, 1);

        // ---- reset at x=30, y=40, then a clean frame ----
        rst = 1'b1; src_on = 0;
        step();
        rst = 1'b0;
        clear_logs(); p = 0; sof_a = 0; sof_b = -1; src_on = 1;
        for (int i = 0; i < 3000 && p < 40 * 64 + 30; i++) step();
        check("mr_position", p, 40 * 64 + 30);
        check("mr_stores", n_st, 40);
        rst = 1'b1;
        step();
        check("mr_rst_rdy", last_rdy, 0);
        check("mr_rst_strobes", {cur_store, snap_outs[38]}, 0);
        rst = 1'b0;
        clear_logs(); sof_a = p + 3;
        step();
        check("mr_after_outs", snap_outs, 0);
        check("mr_after_rdy", last_rdy, 1);
        for (int i = 0; i < 6000 && n_fs == 0; i++) step();
        check("mr_fs", n_fs, 1);
        check("mr_stores_full", n_st, 64);
        check("mr_writes", n_wr, 4096);
        check("mr_wr_bad", wr_bad, 0);
        check("mr_err", n_err, 0);
        check_frame_stores("mr_store_addr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
